instr_fetch_queue: RTL and testbench
====================================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, sets the queue entry count; the legal range is 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-003 Clk  input  1  is the single clock; all state updates on the rising edge.
REQ-004 Rst  input  1  is the reset; it is synchronous and active-high.
REQ-005 Redirect  input  1  is a branch/jump redirect from the decode stage.
REQ-006 RedirectPC  input  32  is the new fetch target, sampled when Redirect=1.
REQ-007 Ld  input  1  means the decode-side IF/ID register accepts the head entry this cycle.
REQ-008 ImemReq  output  1  is the instruction-memory read request.
REQ-009 ImemAddr  output  32  is the request address, valid when ImemReq=1.
REQ-010 ImemRvalid  input  1  is the read-data valid strobe, exactly one cycle after ImemReq.
REQ-011 ImemRdata  input  32  is the instruction word returned with ImemRvalid.
REQ-012 Valid  output  1  means the head entry holds a real instruction.
REQ-013 Instruction  output  32  is the head instruction word.
REQ-014 PCAddResult  output  32  is the head instruction address + 4.
REQ-015 Count  output  clog2(DEPTH+1)  is the current occupancy.

Function
REQ-016 The block SHALL hold FetchPC, a circular FIFO of {Instruction, PCAddResult}, and one in-flight tag {InflightValid, InflightPC}.
REQ-017 The block SHALL issue a request (ImemReq=1, ImemAddr=FetchPC) when Count + InflightValid < DEPTH, Redirect=0 and Rst=0.
  - On issue: FetchPC <= FetchPC+4 (32-bit wrap), InflightValid <= 1, InflightPC <= FetchPC.
REQ-018 A response with ImemRvalid=1 and InflightValid=1 SHALL enqueue {ImemRdata, InflightPC+4} at the tail.
  - A response with InflightValid=0 SHALL be discarded.
REQ-019 The block SHALL dequeue the head when Valid=1 and Ld=1; Ld with Valid=0 has no effect.
REQ-020 Outputs SHALL be registered from FIFO state; an instruction returned in cycle N is visible on Valid/Instruction in cycle N+1 (minimum fetch-to-output latency 2 cycles).
REQ-021 When the queue is empty: Valid=0, Instruction=32'h0000_0000 (NOP), PCAddResult=0.
REQ-022 A simultaneous enqueue and dequeue SHALL leave Count unchanged, including when Count=DEPTH or Count=1.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; the credit rule (REQ-017) SHALL make overflow impossible.
REQ-024 With Ld held at 1 and no redirects, the block SHALL sustain one instruction per cycle after the initial latency.
REQ-025 When Redirect=1, the following SHALL happen in that cycle's update:
  - flush the FIFO (Count<=0, pointers<=0);
  - clear InflightValid;
  - FetchPC <= {RedirectPC[31:2], 2'b00};
  - ImemReq=0.
REQ-026 Redirect SHALL take priority over a simultaneous Ld (the head is discarded, not consumed) and over a simultaneous ImemRvalid (data dropped).
REQ-027 The first request after a redirect SHALL occur in the next cycle, at the redirected address.

Reset
REQ-028 In any cycle with Rst=1, the next state SHALL be: FetchPC=RESET_PC, Count=0, pointers=0, InflightValid=0; the outputs SHALL be Valid=0, Instruction=0, PCAddResult=0, ImemReq=0.
REQ-029 Reset asserted mid-operation SHALL discard all queued and in-flight data; an ImemRvalid in the cycle after reset is ignored.
REQ-030 The first request SHALL be issued in the first cycle with Rst=0.

Structure
REQ-031 The shared package SHALL hold the NOP constant (32'h0), the default RESET_PC, and the {Instruction, PCAddResult} entry typedef.
REQ-032 Storage and pointers SHALL be a single sub-module, fetch_fifo (push, pop, flush, full, empty, count); the credit logic, FetchPC and in-flight tag stay in instr_fetch_queue.

Verification
REQ-033 Reset release, memory returns addr-as-data, Ld=1 continuously -> ImemAddr 0,4,8,... on consecutive cycles; Valid rises 2 cycles after the first request; PCAddResult 4,8,12,... one per cycle.
REQ-034 Ld=0 for 10 cycles with DEPTH=4 -> Count saturates at 4; requests stop with Count+Inflight=4; no entry is lost; on Ld=1 the entries drain in order 0,4,8,12.
REQ-035 Redirect=1 with RedirectPC=32'h0000_0103 while Count=3 and a request is in flight -> Count=0 and Valid=0 next cycle; the next ImemAddr is 32'h100; the stale response is dropped; the first valid PCAddResult is 32'h104.
REQ-036 Redirect, Ld=1 and ImemRvalid=1 in the same cycle -> the head is not consumed; no enqueue; the queue is empty next cycle.
REQ-037 Rst pulsed for one cycle mid-stream with Count=2 -> all outputs zero; the next cycle issues ImemAddr=RESET_PC; the post-reset ImemRvalid is ignored.
REQ-038 Full queue with Ld=1 and a response arriving in the same cycle -> Count stays 4; FIFO order is preserved across pointer wrap-around.

Source files
------------

// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package instr_fetch_queue_pkg;

    // Word presented on Instruction when the queue has nothing to offer.
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    // Fetch address used after reset unless the instance overrides it.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One queued fetch: the instruction word and the address of the next one.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_add;
    } fq_entry_t;

    // Sequential fetch step, wrapping at 32 bits.
    function automatic logic [31:0] pc_step(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// Circular buffer of fetched entries with occupancy tracking and flush.
module fetch_fifo
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  fq_entry_t                  push_data_i,
    input  logic                       pop_i,
    output fq_entry_t                  head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    fq_entry_t     mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rptr_q];

    // A push into a full buffer is accepted only when the head leaves in the same cycle.
    assign do_push = push_i && !flush_i && (!full_o || pop_i);
    assign do_pop  = pop_i  && !flush_i && !empty_o;

    // Next pointer and occupancy values.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = ptr_inc(wptr_q);
        if (do_pop)  rptr_d = ptr_inc(rptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/occupancy state; reset and flush both empty the buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are don't-care until pointed at, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= push_data_i;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues sequential fetches under a credit rule,
// buffers returned words, and presents the head to the decode stage.
// DEPTH is expected in the range 2..16.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       Redirect,
    input  logic [31:0]                RedirectPC,
    input  logic                       Ld,
    output logic                       ImemReq,
    output logic [31:0]                ImemAddr,
    input  logic                       ImemRvalid,
    input  logic [31:0]                ImemRdata,
    output logic                       Valid,
    output logic [31:0]                Instruction,
    output logic [31:0]                PCAddResult,
    output logic [$clog2(DEPTH+1)-1:0] Count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          infl_vld_q, infl_vld_d;
    logic [31:0]   infl_pc_q,  infl_pc_d;

    logic [CW:0]   occupancy;
    logic          issue;
    logic          push, pop;
    fq_entry_t     push_entry, head;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

    // Queued plus in-flight entries must stay below DEPTH, so a response
    // always finds a free slot and the buffer can never overflow.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, infl_vld_q};
    assign issue     = (occupancy < (CW+1)'(DEPTH)) && !Redirect && !Rst;

    assign ImemReq   = issue;
    assign ImemAddr  = fetch_pc_q;

    // Redirect and reset win over both a returning word and a consuming decode.
    assign push = ImemRvalid && infl_vld_q && !Redirect && !Rst && (!fifo_full || pop);
    assign pop  = Ld && !fifo_empty && !Redirect && !Rst;

    assign push_entry = '{instr: ImemRdata, pc_add: pc_step(infl_pc_q)};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (Clk),
        .rst_i       (Rst),
        .flush_i     (Redirect),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Head presentation; an empty queue shows a NOP with a zero address.
    assign Valid       = !fifo_empty && !Rst;
    assign Instruction = Valid ? head.instr  : NOP_INSTR;
    assign PCAddResult = Valid ? head.pc_add : 32'h0;
    assign Count       = fifo_count;

    // Next fetch address and in-flight tag.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        infl_vld_d = infl_vld_q;
        infl_pc_d  = infl_pc_q;
        if (Redirect) begin
            fetch_pc_d = RedirectPC & ~32'h3;
            infl_vld_d = 1'b0;
        end else if (issue) begin
            fetch_pc_d = pc_step(fetch_pc_q);
            infl_vld_d = 1'b1;
            infl_pc_d  = fetch_pc_q;
        end else if (ImemRvalid) begin
            infl_vld_d = 1'b0;
        end
    end

    // Fetch-side state registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            fetch_pc_q <= RESET_PC;
            infl_vld_q <= 1'b0;
            infl_pc_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            infl_vld_q <= infl_vld_d;
            infl_pc_q  <= infl_pc_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue; the memory returns the address as data.
module tb_instr_fetch_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          Clk = 1'b0;
    logic          Rst, Redirect, Ld, ImemRvalid;
    logic [31:0]   RedirectPC, ImemRdata;
    logic          ImemReq, Valid;
    logic [31:0]   ImemAddr, Instruction, PCAddResult;
    logic [CW-1:0] Count;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 Clk = ~Clk;

    instr_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Redirect    (Redirect),
        .RedirectPC  (RedirectPC),
        .Ld          (Ld),
        .ImemReq     (ImemReq),
        .ImemAddr    (ImemAddr),
        .ImemRvalid  (ImemRvalid),
        .ImemRdata   (ImemRdata),
        .Valid       (Valid),
        .Instruction (Instruction),
        .PCAddResult (PCAddResult),
        .Count       (Count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // One clock: sample this cycle's request, then return it one cycle later.
    task automatic tick();
        logic        r;
        logic [31:0] a;
        #1;
        r = ImemReq;
        a = ImemAddr;
        @(posedge Clk);
        #1;
        ImemRvalid = r;
        ImemRdata  = a;
    endtask

    task automatic do_reset();
        Rst      = 1'b1;
        Ld       = 1'b0;
        Redirect = 1'b0;
        tick();
        Rst = 1'b0;
    endtask

    initial begin
        Rst = 1'b1; Redirect = 1'b0; RedirectPC = '0; Ld = 1'b0;
        ImemRvalid = 1'b0; ImemRdata = '0;

        // Reset state
        tick(); tick();
        #1;
        chk("rst_valid", 32'(Valid),  32'd0);
        chk("rst_instr", Instruction, 32'd0);
        chk("rst_pcadd", PCAddResult, 32'd0);
        chk("rst_req",   32'(ImemReq), 32'd0);
        chk("rst_count", 32'(Count),  32'd0);

        // Streaming with Ld held high
        Rst = 1'b0; Ld = 1'b1;
        #1;
        chk("s_req0",   32'(ImemReq), 32'd1);
        chk("s_addr0",  ImemAddr,     32'd0);
        chk("s_valid0", 32'(Valid),   32'd0);
        tick();
        chk("s_valid1", 32'(Valid),   32'd0);
        chk("s_addr1",  ImemAddr,     32'd4);
        tick();
        for (int k = 2; k < 8; k++) begin
            chk("s_valid", 32'(Valid),  32'd1);
            chk("s_pcadd", PCAddResult, 32'(4 * (k - 1)));
            chk("s_addr",  ImemAddr,    32'(4 * k));
            chk("s_count", 32'(Count),  32'd1);
            tick();
        end

        // Back-pressure to full, then drain in order across pointer wrap
        do_reset();
        Ld = 1'b0;
        repeat (10) tick();
        chk("bp_count", 32'(Count),   32'd4);
        chk("bp_req",   32'(ImemReq), 32'd0);
        chk("bp_valid", 32'(Valid),   32'd1);
        Ld = 1'b1;
        for (int k = 0; k < 14; k++) begin
            #1;
            chk("dr_valid", 32'(Valid),  32'd1);
            chk("dr_instr", Instruction, 32'(4 * k));
            chk("dr_pcadd", PCAddResult, 32'(4 * k + 4));
            if (k == 1) begin
                chk("dr_count1", 32'(Count), 32'd3);
                chk("dr_addr1",  ImemAddr,   32'd16);
            end
            if (k >= 3) chk("dr_count", 32'(Count), 32'd2);
            tick();
        end

        // Redirect with three queued and one in flight
        do_reset();
        Ld = 1'b0;
        repeat (4) tick();
        chk("rd_count_pre", 32'(Count), 32'd3);
        Redirect = 1'b1; RedirectPC = 32'h0000_0103;
        #1;
        chk("rd_req", 32'(ImemReq), 32'd0);
        tick();
        Redirect = 1'b0;
        ImemRvalid = 1'b1; ImemRdata = 32'hDEAD_BEEF;
        #1;
        chk("rd_count", 32'(Count),   32'd0);
        chk("rd_valid", 32'(Valid),   32'd0);
        chk("rd_req1",  32'(ImemReq), 32'd1);
        chk("rd_addr",  ImemAddr,     32'h0000_0100);
        tick();
        chk("rd_stale_count", 32'(Count), 32'd0);
        chk("rd_addr2",       ImemAddr,   32'h0000_0104);
        tick();
        chk("rd_valid2", 32'(Valid),  32'd1);
        chk("rd_instr",  Instruction, 32'h0000_0100);
        chk("rd_pcadd",  PCAddResult, 32'h0000_0104);

        // Redirect together with Ld and a returning word
        Ld = 1'b1; Redirect = 1'b1; RedirectPC = 32'h0000_0200;
        tick();
        Redirect = 1'b0; Ld = 1'b0;
        #1;
        chk("rl_count", 32'(Count),  32'd0);
        chk("rl_valid", 32'(Valid),  32'd0);
        chk("rl_instr", Instruction, 32'd0);
        chk("rl_addr",  ImemAddr,    32'h0000_0200);

        // Reset pulse mid-stream with two queued
        do_reset();
        Ld = 1'b0;
        repeat (3) tick();
        chk("mr_count_pre", 32'(Count), 32'd2);
        Rst = 1'b1;
        #1;
        chk("mr_valid", 32'(Valid),   32'd0);
        chk("mr_instr", Instruction,  32'd0);
        chk("mr_pcadd", PCAddResult,  32'd0);
        chk("mr_req",   32'(ImemReq), 32'd0);
        tick();
        Rst = 1'b0;
        ImemRvalid = 1'b1; ImemRdata = 32'h0000_0055;
        #1;
        chk("mr_req1",  32'(ImemReq), 32'd1);
        chk("mr_addr",  ImemAddr,     32'd0);
        chk("mr_count", 32'(Count),   32'd0);
        tick();
        chk("mr_spur_count", 32'(Count), 32'd0);
        tick();
        chk("mr_count2", 32'(Count),  32'd1);
        chk("mr_instr2", Instruction, 32'd0);
        chk("mr_pcadd2", PCAddResult, 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
